// File: rtl/decode_pkg.sv
// Shared decode constants: ALU op encodings, opcode/funct3/funct7 values, stage states.
// Optional ebreak detection elsewhere is enabled by DECODE_EBREAK_EN.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // The alt bit (inst[30]) selects SUB/SRA; callers check its legality separately.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV decode of one instruction word into ALU control fields.
// Macro DECODE_EBREAK_EN adds ebreak recognition (o_ebreak); otherwise ebreak is illegal.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [3:0]      o_aluop,
  output logic            o_wen,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_imm,
  output logic            o_src1_pc_sel,
  output logic            o_src2_imm_sel,
`ifdef DECODE_EBREAK_EN
  output logic            o_ebreak,
`endif
  output logic            o_illegal
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]     w_opc;
  logic [2:0]     w_f3;
  logic [6:0]     w_f7;
  logic [31:0]    w_u32;
  logic           w_legal;
  logic           w_ebreak;
  logic           w_shift_ok;
  alu_op_e        w_aluop;
  logic           w_src1;
  logic           w_src2;
  logic [XLEN-1:0] w_imm;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_f7  = i_inst[31:25];
  assign w_u32 = {i_inst[31:12], 12'b0};

  // Upper shift bits must be zero except inst[30] on right shifts; inst[25] is shamt only at XLEN=64.
  assign w_shift_ok = !i_inst[31] && (i_inst[29:26] == 4'b0) &&
                      (!i_inst[30] || (w_f3 == F3_SR)) &&
                      ((XLEN == 64) || !i_inst[25]);

  always_comb begin
    w_legal  = 1'b0;
    w_ebreak = 1'b0;
    w_aluop  = ALU_ADD;
    w_src1   = 1'b0;
    w_src2   = 1'b0;
    w_imm    = '0;
    case (w_opc)
      OP_IMM: begin
        w_src2 = 1'b1;
        if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
          w_legal = w_shift_ok;
          w_aluop = f3_to_alu(w_f3, i_inst[30]);
          w_imm   = XLEN'(i_inst[20 +: SHW]);
        end else begin
          w_legal = 1'b1;
          w_aluop = f3_to_alu(w_f3, 1'b0);
          w_imm   = XLEN'($signed(i_inst[31:20]));
        end
      end
      OP: begin
        w_legal = (w_f7 == F7_BASE) ||
                  ((w_f7 == F7_ALT) && (w_f3 == F3_ADD || w_f3 == F3_SR));
        w_aluop = f3_to_alu(w_f3, i_inst[30]);
      end
      LUI: begin
        w_legal = 1'b1;
        w_aluop = ALU_PASSB;
        w_src2  = 1'b1;
        w_imm   = XLEN'($signed(w_u32));
      end
      AUIPC: begin
        w_legal = 1'b1;
        w_aluop = ALU_ADD;
        w_src1  = 1'b1;
        w_src2  = 1'b1;
        w_imm   = XLEN'($signed(w_u32));
      end
`ifdef DECODE_EBREAK_EN
      SYSTEM: begin
        w_legal  = (i_inst == INST_EBREAK);
        w_ebreak = (i_inst == INST_EBREAK);
      end
`endif
      default: ;
    endcase
    if (!w_legal) begin
      w_aluop = ALU_ADD;
      w_src1  = 1'b0;
      w_src2  = 1'b0;
      w_imm   = '0;
    end
  end

  assign o_aluop        = w_aluop;
  assign o_rd           = i_inst[11:7];
  assign o_rs1          = i_inst[19:15];
  assign o_rs2          = i_inst[24:20];
  assign o_imm          = w_imm;
  assign o_src1_pc_sel  = w_src1;
  assign o_src2_imm_sel = w_src2;
  assign o_illegal      = !w_legal;
  assign o_wen          = w_legal && !w_ebreak && (i_inst[11:7] != 5'd0);
`ifdef DECODE_EBREAK_EN
  assign o_ebreak       = w_ebreak;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage, 1-cycle latency; valid/ready with outputs held while stalled.
// Macro DECODE_EBREAK_EN: accepted ebreak raises halted and parks the stage until rst.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      aluop,
  output logic            wen,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            src1_pc_sel,
  output logic            src2_imm_sel,
  output logic            illegal,
  output logic            halted
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [3:0]      r_aluop;
  logic            r_wen;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_imm;
  logic            r_src1;
  logic            r_src2;
  logic            r_illegal;

  logic [3:0]      w_aluop;
  logic            w_wen;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm;
  logic            w_src1;
  logic            w_src2;
  logic            w_illegal;
`ifdef DECODE_EBREAK_EN
  logic            w_ebreak;
  logic            r_halted;
`endif

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .i_inst         (inst),
    .o_aluop        (w_aluop),
    .o_wen          (w_wen),
    .o_rd           (w_rd),
    .o_rs1          (w_rs1),
    .o_rs2          (w_rs2),
    .o_imm          (w_imm),
    .o_src1_pc_sel  (w_src1),
    .o_src2_imm_sel (w_src2),
`ifdef DECODE_EBREAK_EN
    .o_ebreak       (w_ebreak),
`endif
    .o_illegal      (w_illegal)
  );

  assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
`ifdef DECODE_EBREAK_EN
    if (w_accept && w_ebreak) w_state_nxt = ST_HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Reset wins over any handshake in the same cycle, dropping a stalled entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_aluop     <= '0;
      r_wen       <= 1'b0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_src1      <= 1'b0;
      r_src2      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= in_pc;
      r_aluop     <= w_aluop;
      r_wen       <= w_wen;
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_imm       <= w_imm;
      r_src1      <= w_src1;
      r_src2      <= w_src2;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DECODE_EBREAK_EN
  always_ff @(posedge clk) begin
    if (rst)                      r_halted <= 1'b0;
    else if (w_accept && w_ebreak) r_halted <= 1'b1;
  end
  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign aluop        = r_aluop;
  assign wen          = r_wen;
  assign rd           = r_rd;
  assign rs1          = r_rs1;
  assign rs2          = r_rs2;
  assign imm          = r_imm;
  assign src1_pc_sel  = r_src1;
  assign src2_imm_sel = r_src2;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32); ebreak section follows DECODE_EBREAK_EN.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  aluop;
  logic        wen;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        src1_pc_sel;
  logic        src2_imm_sel;
  logic        illegal;
  logic        halted;

  int n_err = 0;
  int n_checks = 0;
  logic [31:0] pc_q = 32'h200;

  decode_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst         (inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .aluop        (aluop),
    .wen          (wen),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .src1_pc_sel  (src1_pc_sel),
    .src2_imm_sel (src2_imm_sel),
    .illegal      (illegal),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [31:0] i, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    inst      = i;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  // Present one instruction (back-to-back with the previous call) and check it one cycle later.
  task automatic dec(input string tag, input logic [31:0] i, input logic [3:0] a, input logic w,
                     input logic [4:0] r, input logic [31:0] im, input logic s1, input logic s2,
                     input logic il);
    logic [31:0] pc;
    pc = pc_q;
    pc_q = pc_q + 32'd4;
    put(1'b1, i, pc, 1'b1);
    @(negedge clk);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".aluop"}, 64'(aluop), 64'(a));
    chk({tag, ".wen"}, 64'(wen), 64'(w));
    chk({tag, ".rd"}, 64'(rd), 64'(r));
    chk({tag, ".imm"}, 64'(imm), 64'(im));
    chk({tag, ".src1"}, 64'(src1_pc_sel), 64'(s1));
    chk({tag, ".src2"}, 64'(src2_imm_sel), 64'(s2));
    chk({tag, ".illegal"}, 64'(illegal), 64'(il));
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(pc));
  endtask

  function automatic logic [31:0] addi_x(input int n);
    return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
  endfunction

  initial begin
    rst = 1'b1;
    put(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.aluop", 64'(aluop), 64'd0);
    chk("rst.imm", 64'(imm), 64'd0);
    chk("rst.out_pc", 64'(out_pc), 64'd0);
    chk("rst.illegal", 64'(illegal), 64'd0);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // single addi, then drain with nothing new accepted
    put(1'b1, 32'h0050_0093, 32'h100, 1'b1);
    @(negedge clk);
    put(1'b0, 32'h0, 32'h0, 1'b1);
    chk("addi.out_valid", 64'(out_valid), 64'd1);
    chk("addi.aluop", 64'(aluop), 64'd0);
    chk("addi.rd", 64'(rd), 64'd1);
    chk("addi.wen", 64'(wen), 64'd1);
    chk("addi.src2", 64'(src2_imm_sel), 64'd1);
    chk("addi.imm", 64'(imm), 64'd5);
    chk("addi.out_pc", 64'(out_pc), 64'h100);
    @(negedge clk);
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // back-to-back decode vectors
    dec("sub",   32'h4020_81B3, 4'd1,  1'b1, 5'd3,  32'h0,        1'b0, 1'b0, 1'b0);
    chk("sub.rs1", 64'(rs1), 64'd1);
    chk("sub.rs2", 64'(rs2), 64'd2);
    dec("lui",   32'h1234_52B7, 4'd10, 1'b1, 5'd5,  32'h1234_5000, 1'b0, 1'b1, 1'b0);
    dec("auipc", 32'h8000_0317, 4'd0,  1'b1, 5'd6,  32'h8000_0000, 1'b1, 1'b1, 1'b0);
    dec("addim1",32'hFFF0_0093, 4'd0,  1'b1, 5'd1,  32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    dec("srai",  32'h4032_5213, 4'd7,  1'b1, 5'd4,  32'h3,        1'b0, 1'b1, 1'b0);
    chk("srai.rs1", 64'(rs1), 64'd4);
    dec("sltu",  32'h0020_B3B3, 4'd4,  1'b1, 5'd7,  32'h0,        1'b0, 1'b0, 1'b0);
    dec("andi",  32'h0F00_F113, 4'd9,  1'b1, 5'd2,  32'hF0,       1'b0, 1'b1, 1'b0);
    dec("nop",   32'h0000_0013, 4'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0);
    dec("ones",  32'hFFFF_FFFF, 4'd0,  1'b0, 5'd31, 32'h0,        1'b0, 1'b0, 1'b1);
    dec("slli25",32'h0200_9093, 4'd0,  1'b0, 5'd1,  32'h0,        1'b0, 1'b0, 1'b1);
    dec("xoralt",32'h4020_C1B3, 4'd0,  1'b0, 5'd3,  32'h0,        1'b0, 1'b0, 1'b1);
    put(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("stream.end_valid", 64'(out_valid), 64'd0);

    // stall: A accepted, downstream stalls three cycles while B waits
    put(1'b1, addi_x(1), 32'h300, 1'b1);
    @(negedge clk);
    put(1'b1, addi_x(2), 32'h304, 1'b0);
    #1;
    chk("stall1.in_ready", 64'(in_ready), 64'd0);
    chk("stall1.rd", 64'(rd), 64'd1);
    @(negedge clk);
    chk("stall2.out_valid", 64'(out_valid), 64'd1);
    chk("stall2.rd", 64'(rd), 64'd1);
    chk("stall2.imm", 64'(imm), 64'd1);
    chk("stall2.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("stall3.rd", 64'(rd), 64'd1);
    chk("stall3.out_pc", 64'(out_pc), 64'h300);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("strm.b.rd", 64'(rd), 64'd2);
    chk("strm.b.pc", 64'(out_pc), 64'h304);
    put(1'b1, addi_x(3), 32'h308, 1'b1);
    @(negedge clk);
    chk("strm.c.rd", 64'(rd), 64'd3);
    chk("strm.c.valid", 64'(out_valid), 64'd1);
    put(1'b1, addi_x(4), 32'h30C, 1'b1);
    @(negedge clk);
    chk("strm.d.rd", 64'(rd), 64'd4);
    chk("strm.d.imm", 64'(imm), 64'd4);
    put(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("strm.end_valid", 64'(out_valid), 64'd0);

    // ebreak
    put(1'b1, 32'h0010_0073, 32'h400, 1'b1);
    @(negedge clk);
    put(1'b1, addi_x(1), 32'h404, 1'b1);
`ifdef DECODE_EBREAK_EN
    chk("ebrk.out_valid", 64'(out_valid), 64'd1);
    chk("ebrk.halted", 64'(halted), 64'd1);
    chk("ebrk.illegal", 64'(illegal), 64'd0);
    chk("ebrk.wen", 64'(wen), 64'd0);
    #1;
    chk("ebrk.in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("halt.in_ready", 64'(in_ready), 64'd0);
      chk("halt.halted", 64'(halted), 64'd1);
    end
    chk("halt.out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    put(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("unhalt.halted", 64'(halted), 64'd0);
    chk("unhalt.in_ready", 64'(in_ready), 64'd1);
`else
    chk("ebrk.out_valid", 64'(out_valid), 64'd1);
    chk("ebrk.illegal", 64'(illegal), 64'd1);
    chk("ebrk.halted", 64'(halted), 64'd0);
    chk("ebrk.wen", 64'(wen), 64'd0);
    #1;
    chk("ebrk.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    put(1'b0, 32'h0, 32'h0, 1'b1);
    chk("postebrk.rd", 64'(rd), 64'd1);
    chk("postebrk.halted", 64'(halted), 64'd0);
    @(negedge clk);
`endif

    // reset during a stall with a competing handshake
    put(1'b1, addi_x(2), 32'h500, 1'b1);
    @(negedge clk);
    put(1'b1, addi_x(3), 32'h504, 1'b0);
    @(negedge clk);
    chk("rstall.out_valid", 64'(out_valid), 64'd1);
    chk("rstall.rd", 64'(rd), 64'd2);
    rst = 1'b1;
    put(1'b1, addi_x(3), 32'h504, 1'b1);
    @(negedge clk);
    chk("rstall.cleared_valid", 64'(out_valid), 64'd0);
    chk("rstall.rd0", 64'(rd), 64'd0);
    chk("rstall.imm0", 64'(imm), 64'd0);
    chk("rstall.wen0", 64'(wen), 64'd0);
    chk("rstall.pc0", 64'(out_pc), 64'd0);
    chk("rstall.src2", 64'(src2_imm_sel), 64'd0);
    rst = 1'b0;
    put(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("rstall.in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
